// File: rtl/pid_filt_gate.sv
// pid_filt_gate: holds each payload packet in one of two ping-pong banks
// until the matcher's verdict, then replays matched packets tagged with
// their list number and discards the rest.
// Ports:
//   payload_clk/payload_rst_n      clock, async active-low reset
//   payload_in_*                   input byte stream (start/end qualified)
//   search_over/t_match/listnum    verdict strobe from the matcher
//   payload_out_*                  replay stream, valid/ready handshake
//   in_overflow                    pulse on a no-bank or oversize drop
//   pkt_pass_cnt/pkt_drop_cnt      saturating packet counters
module pid_filt_gate #(
  parameter int PAYLOAD_DATA_WIDTH = 8,
  parameter int BANK_DEPTH         = 256,
  parameter int VERDICT_TIMEOUT    = 64
) (
  input  logic                          payload_clk,
  input  logic                          payload_rst_n,
  input  logic                          payload_in_valid,
  input  logic                          payload_in_start,
  input  logic                          payload_in_end,
  input  logic [PAYLOAD_DATA_WIDTH-1:0] payload_in_data,
  input  logic                          search_over,
  input  logic                          t_match,
  input  logic [PAYLOAD_DATA_WIDTH-1:0] t_match_listnum,
  input  logic                          payload_out_ready,
  output logic                          payload_out_valid,
  output logic                          payload_out_start,
  output logic                          payload_out_end,
  output logic [PAYLOAD_DATA_WIDTH-1:0] payload_out_data,
  output logic [PAYLOAD_DATA_WIDTH-1:0] payload_out_listnum,
  output logic                          in_overflow,
  output logic [15:0]                   pkt_pass_cnt,
  output logic [15:0]                   pkt_drop_cnt
);
  localparam int DW = PAYLOAD_DATA_WIDTH;
  localparam int AW = $clog2(BANK_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(VERDICT_TIMEOUT) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(BANK_DEPTH);
  localparam logic [LW-1:0] LEN_ONE = LW'(1);
  localparam logic [TW-1:0] TMO_LAST = TW'(VERDICT_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE = TW'(1);

  typedef enum logic [1:0] {
    W_IDLE, W_FILL, W_WAIT_VERDICT, W_SKIP
  } wst_e;
  typedef enum logic [1:0] {
    R_IDLE, R_PREFETCH, R_OUT
  } rdst_e;

  logic [DW-1:0] mem [0:2*BANK_DEPTH-1];

  wst_e              w_st_q, w_st_d;
  logic [LW-1:0]     wlen_q, wlen_d;
  logic              vseen_q, vseen_d;
  logic              vmatch_q, vmatch_d;
  logic [DW-1:0]     vlist_q, vlist_d;
  logic              trunc_q, trunc_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              wr_bank_q, wr_bank_d;
  logic [1:0]        full_q;
  logic [1:0][LW-1:0] len_q;
  logic [1:0][DW-1:0] list_q;
  logic              ovf_q;
  logic [15:0]       pass_q, drop_q;

  logic          we;
  logic [AW-1:0] waddr;
  logic          pass_ev, drop_ev, ovf_ev;
  logic          do_commit, begin_pkt, sv, rel_ev;

  rdst_e         r_st_q;
  logic          rd_bank_q;
  logic [LW-1:0] rcnt_q;
  logic          ov_q, os_q, oe_q;
  logic [DW-1:0] od_q, ol_q;

  assign sv = payload_in_valid & payload_in_start;
  assign rel_ev = (r_st_q == R_OUT) & payload_out_ready & oe_q;

  always_comb begin
    w_st_d    = w_st_q;
    wlen_d    = wlen_q;
    vseen_d   = vseen_q;
    vmatch_d  = vmatch_q;
    vlist_d   = vlist_q;
    trunc_d   = trunc_q;
    tmo_d     = tmo_q;
    wr_bank_d = wr_bank_q;
    we        = 1'b0;
    waddr     = '0;
    pass_ev   = 1'b0;
    drop_ev   = 1'b0;
    ovf_ev    = 1'b0;
    do_commit = 1'b0;
    begin_pkt = 1'b0;
    unique case (w_st_q)
      W_IDLE: begin_pkt = sv;
      W_FILL: begin
        if (sv) begin
          drop_ev   = 1'b1;
          begin_pkt = 1'b1;
        end else begin
          if (search_over) begin
            vseen_d  = 1'b1;
            vmatch_d = t_match;
            vlist_d  = t_match_listnum;
          end
          if (payload_in_valid) begin
            if (wlen_q == DEPTH_L) begin
              trunc_d = 1'b1;
            end else begin
              we     = 1'b1;
              waddr  = wlen_q[AW-1:0];
              wlen_d = wlen_q + LEN_ONE;
            end
            if (payload_in_end) begin
              if (vseen_d) begin
                do_commit = 1'b1;
              end else begin
                w_st_d = W_WAIT_VERDICT;
                tmo_d  = '0;
              end
            end
          end
        end
      end
      W_WAIT_VERDICT: begin
        // A new start abandons the pending packet as if it timed out.
        if (sv) begin
          drop_ev   = 1'b1;
          begin_pkt = 1'b1;
        end else if (search_over) begin
          do_commit = 1'b1;
          vmatch_d  = t_match;
          vlist_d   = t_match_listnum;
        end else if (tmo_q == TMO_LAST) begin
          drop_ev = 1'b1;
          w_st_d  = W_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      W_SKIP: begin
        if (sv) begin
          begin_pkt = 1'b1;
        end else if (payload_in_valid && payload_in_end) begin
          w_st_d = W_IDLE;
        end
      end
      default: w_st_d = W_IDLE;
    endcase
    if (do_commit) begin
      w_st_d = W_IDLE;
      if (vmatch_d && !trunc_d) begin
        pass_ev   = 1'b1;
        wr_bank_d = ~wr_bank_q;
      end else begin
        drop_ev = 1'b1;
        ovf_ev  = trunc_d;
      end
    end
    if (begin_pkt) begin
      if (!full_q[wr_bank_q]) begin
        we      = 1'b1;
        waddr   = '0;
        wlen_d  = LEN_ONE;
        vseen_d = 1'b0;
        trunc_d = 1'b0;
        tmo_d   = '0;
        w_st_d  = payload_in_end ? W_WAIT_VERDICT : W_FILL;
      end else begin
        ovf_ev  = 1'b1;
        drop_ev = 1'b1;
        w_st_d  = payload_in_end ? W_IDLE : W_SKIP;
      end
    end
  end

  always_ff @(posedge payload_clk) begin
    if (we) mem[{wr_bank_q, waddr}] <= payload_in_data;
  end

  always_ff @(posedge payload_clk or negedge payload_rst_n) begin
    if (!payload_rst_n) begin
      w_st_q    <= W_IDLE;
      wlen_q    <= '0;
      vseen_q   <= 1'b0;
      vmatch_q  <= 1'b0;
      vlist_q   <= '0;
      trunc_q   <= 1'b0;
      tmo_q     <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= '0;
      len_q     <= '0;
      list_q    <= '0;
      ovf_q     <= 1'b0;
      pass_q    <= '0;
      drop_q    <= '0;
    end else begin
      w_st_q    <= w_st_d;
      wlen_q    <= wlen_d;
      vseen_q   <= vseen_d;
      vmatch_q  <= vmatch_d;
      vlist_q   <= vlist_d;
      trunc_q   <= trunc_d;
      tmo_q     <= tmo_d;
      wr_bank_q <= wr_bank_d;
      ovf_q     <= ovf_ev;
      if (pass_ev && pass_q != 16'hFFFF) pass_q <= pass_q + 16'd1;
      if (drop_ev && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (pass_ev) begin
        len_q[wr_bank_q]  <= wlen_d;
        list_q[wr_bank_q] <= vlist_d;
      end
      // Commit always targets the bank being filled, release the one
      // being drained, so both can land in the same cycle.
      for (int b = 0; b < 2; b++) begin
        if (pass_ev && wr_bank_q == b[0]) full_q[b] <= 1'b1;
        else if (rel_ev && rd_bank_q == b[0]) full_q[b] <= 1'b0;
      end
    end
  end

  always_ff @(posedge payload_clk or negedge payload_rst_n) begin
    if (!payload_rst_n) begin
      r_st_q    <= R_IDLE;
      rd_bank_q <= 1'b0;
      rcnt_q    <= '0;
      ov_q      <= 1'b0;
      os_q      <= 1'b0;
      oe_q      <= 1'b0;
      od_q      <= '0;
      ol_q      <= '0;
    end else begin
      unique case (r_st_q)
        R_IDLE: if (full_q[rd_bank_q]) r_st_q <= R_PREFETCH;
        R_PREFETCH: begin
          od_q   <= mem[{rd_bank_q, {AW{1'b0}}}];
          ol_q   <= list_q[rd_bank_q];
          os_q   <= 1'b1;
          oe_q   <= (len_q[rd_bank_q] == LEN_ONE);
          ov_q   <= 1'b1;
          rcnt_q <= LEN_ONE;
          r_st_q <= R_OUT;
        end
        R_OUT: begin
          if (payload_out_ready) begin
            if (oe_q) begin
              ov_q      <= 1'b0;
              os_q      <= 1'b0;
              oe_q      <= 1'b0;
              rd_bank_q <= ~rd_bank_q;
              r_st_q    <= R_IDLE;
            end else begin
              od_q   <= mem[{rd_bank_q, rcnt_q[AW-1:0]}];
              os_q   <= 1'b0;
              oe_q   <= (rcnt_q == len_q[rd_bank_q] - LEN_ONE);
              rcnt_q <= rcnt_q + LEN_ONE;
            end
          end
        end
        default: r_st_q <= R_IDLE;
      endcase
    end
  end

  assign payload_out_valid   = ov_q;
  assign payload_out_start   = os_q;
  assign payload_out_end     = oe_q;
  assign payload_out_data    = od_q;
  assign payload_out_listnum = ol_q;
  assign in_overflow         = ovf_q;
  assign pkt_pass_cnt        = pass_q;
  assign pkt_drop_cnt        = drop_q;
endmodule

// File: tb/tb_pid_filt_gate.sv
// tb_pid_filt_gate: table of packet scenarios plus hand-written sequences;
// replayed bytes are checked against a queue of expected bytes.
module tb_pid_filt_gate;
  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_start, in_end;
  logic [7:0] in_data;
  logic search_over, t_match;
  logic [7:0] t_listnum;
  logic out_ready;
  logic out_valid, out_start, out_end;
  logic [7:0] out_data, out_listnum;
  logic in_overflow;
  logic [15:0] pass_cnt, drop_cnt;

  always #5 clk = ~clk;

  pid_filt_gate dut (
    .payload_clk        (clk),
    .payload_rst_n      (rst_n),
    .payload_in_valid   (in_valid),
    .payload_in_start   (in_start),
    .payload_in_end     (in_end),
    .payload_in_data    (in_data),
    .search_over        (search_over),
    .t_match            (t_match),
    .t_match_listnum    (t_listnum),
    .payload_out_ready  (out_ready),
    .payload_out_valid  (out_valid),
    .payload_out_start  (out_start),
    .payload_out_end    (out_end),
    .payload_out_data   (out_data),
    .payload_out_listnum(out_listnum),
    .in_overflow        (in_overflow),
    .pkt_pass_cnt       (pass_cnt),
    .pkt_drop_cnt       (drop_cnt)
  );

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
    logic [7:0] l;
  } item_t;

  typedef struct {
    int         len;
    bit         match;
    logic [7:0] ls;
    int         vat;
    bit         pass;
    bit         ovf;
  } vec_t;

  item_t sb[$];
  vec_t  vecs[10];
  int checks = 0;
  int failures = 0;
  int ovf_seen = 0;
  int exp_pass = 0;
  int exp_drop = 0;
  int exp_ovf = 0;
  bit rnd_ready = 0;
  bit hold_pend = 0;
  logic [18:0] hold_v;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int len, input bit match,
                      input logic [7:0] ls, input int vat,
                      input bit push);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      d = 8'($urandom_range(0, 255));
      in_valid = 1'b1;
      in_start = (i == 0);
      in_end = (i == len - 1);
      in_data = d;
      search_over = (i == vat);
      t_match = match;
      t_listnum = ls;
      if (push) sb.push_back('{d, i == 0, i == len - 1, ls});
      tick();
    end
    in_valid = 1'b0;
    in_start = 1'b0;
    in_end = 1'b0;
    search_over = 1'b0;
    if (vat >= len) begin
      repeat (vat - len) tick();
      search_over = 1'b1;
      tick();
      search_over = 1'b0;
    end
  endtask

  task automatic chk_counts(string tag);
    chk({tag, "_pass_cnt"}, 32'(pass_cnt), 32'(exp_pass));
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
    chk({tag, "_ovf_pulses"}, 32'(ovf_seen), 32'(exp_ovf));
    chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend)
        chk("hold_stable",
            {out_valid, out_start, out_end, out_data, out_listnum},
            hold_v);
      hold_pend = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", {out_start, out_end, out_data}, 32'hDEAD);
        end else begin
          item_t it;
          it = sb.pop_front();
          chk("out_byte", {out_start, out_end, out_listnum, out_data},
              {it.s, it.e, it.l, it.d});
        end
      end else if (out_valid) begin
        hold_pend = 1'b1;
        hold_v = {out_valid, out_start, out_end, out_data, out_listnum};
      end
      if (in_overflow) ovf_seen++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int k;
    int d0;
    vecs[0] = '{16, 1, 8'd5, 10, 1, 0};
    vecs[1] = '{16, 0, 8'd5, 10, 0, 0};
    vecs[2] = '{16, 1, 8'd6, -1, 0, 0};
    vecs[3] = '{16, 1, 8'd7, 18, 1, 0};
    vecs[4] = '{300, 1, 8'd9, 10, 0, 1};
    vecs[5] = '{1, 1, 8'hA5, 3, 1, 0};
    vecs[6] = '{256, 1, 8'h11, 100, 1, 0};
    vecs[7] = '{257, 1, 8'h22, 100, 0, 1};
    vecs[8] = '{16, 1, 8'hFE, 15, 1, 0};
    vecs[9] = '{5, 0, 8'd1, 7, 0, 0};

    rst_n = 1'b0;
    in_valid = 0; in_start = 0; in_end = 0; in_data = 0;
    search_over = 0; t_match = 0; t_listnum = 0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_outputs",
        {out_valid, out_start, out_end, out_data, out_listnum, in_overflow},
        32'd0);
    chk("rst_pass_cnt", 32'(pass_cnt), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 10; v++) begin
      send(vecs[v].len, vecs[v].match, vecs[v].ls, vecs[v].vat,
           vecs[v].pass);
      if (vecs[v].pass) exp_pass++;
      else exp_drop++;
      if (vecs[v].ovf) exp_ovf++;
      repeat (300) tick();
      chk_counts($sformatf("vec%0d", v));
    end

    // Timeout lands exactly VERDICT_TIMEOUT cycles after the end byte.
    d0 = 32'(drop_cnt);
    send(16, 1, 8'd3, -1, 0);
    k = 1;
    while (k <= 200) begin
      tick();
      if (32'(drop_cnt) != d0) break;
      k++;
    end
    chk("timeout_cycles", 32'(k), 32'd64);
    exp_drop++;
    repeat (5) tick();
    chk_counts("timeout");

    // Output valid rises two cycles after the commit edge.
    send(16, 1, 8'd44, 10, 1);
    chk("lat_c0", 32'(out_valid), 32'd0);
    tick();
    chk("lat_c1", 32'(out_valid), 32'd0);
    tick();
    chk("lat_c2", 32'(out_valid), 32'd1);
    exp_pass++;
    repeat (30) tick();
    chk_counts("latency");

    // Three back-to-back packets with the sink stalled.
    out_ready = 1'b0;
    send(188, 1, 8'd1, 10, 1);
    send(188, 1, 8'd2, 10, 1);
    send(188, 1, 8'd3, 10, 0);
    exp_pass += 2;
    exp_drop++;
    exp_ovf++;
    repeat (10) tick();
    chk("b2b_sb_held", 32'(sb.size()), 32'd376);
    out_ready = 1'b1;
    repeat (450) tick();
    chk_counts("b2b");

    // Random backpressure on a 20-byte packet.
    rnd_ready = 1'b1;
    send(20, 1, 8'd33, 12, 1);
    repeat (200) tick();
    rnd_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    repeat (10) tick();
    exp_pass++;
    chk_counts("rnd_ready");

    // Reset in the middle of a replay.
    send(40, 1, 8'd77, 10, 1);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_outputs",
        {out_valid, out_start, out_end, out_data, out_listnum, in_overflow},
        32'd0);
    chk("midrst_pass_cnt", 32'(pass_cnt), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    exp_pass = 0;
    exp_drop = 0;
    exp_ovf = 0;
    ovf_seen = 0;
    repeat (10) tick();
    chk("postrst_idle", 32'(out_valid), 32'd0);
    send(16, 1, 8'd12, 10, 1);
    exp_pass++;
    repeat (30) tick();
    chk_counts("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pid_filt_gate.md
Name: pid_filt_gate

Overview:
- Downstream companion of the PID/section filter matcher. Buffers each incoming payload packet while the matcher searches its table, captures the verdict (search_over / t_match / t_match_listnum), then replays matched packets tagged with list number and discards the rest.
- Two ping-pong packet banks let packet N+1 be captured while packet N is replayed. Single clock domain: payload_clk.

Parameters:
- PAYLOAD_DATA_WIDTH, 8, width of payload data and list number.
- BANK_DEPTH, 256, bytes per bank; longer packets are dropped.
- VERDICT_TIMEOUT, 64, cycles allowed after payload_in_end for search_over before the packet is dropped.

Ports:
- payload_clk, in, 1, clock.
- payload_rst_n, in, 1, asynchronous active-low reset.
- payload_in_valid, payload_in_start, payload_in_end, in, 1 each, input byte qualifiers; same stream as fed to the matcher.
- payload_in_data, in, PAYLOAD_DATA_WIDTH, input byte.
- search_over, in, 1, one-cycle verdict strobe from the matcher.
- t_match, in, 1, match flag; valid when search_over=1.
- t_match_listnum, in, PAYLOAD_DATA_WIDTH, matching entry index; valid when search_over=1.
- payload_out_ready, in, 1, downstream accept.
- payload_out_valid, payload_out_start, payload_out_end, out, 1 each, output qualifiers.
- payload_out_data, out, PAYLOAD_DATA_WIDTH, output byte.
- payload_out_listnum, out, PAYLOAD_DATA_WIDTH, list number of the packet being replayed; constant for the whole packet.
- in_overflow, out, 1, one-cycle pulse when an input packet is dropped for lack of a free bank or length > BANK_DEPTH.
- pkt_pass_cnt, out, 16, packets committed for replay; saturates at 16'hFFFF.
- pkt_drop_cnt, out, 16, packets discarded for any reason; saturates at 16'hFFFF.

Behaviour:
- Reset: all outputs 0; both banks empty; wr_bank = rd_bank = 0; both FSMs idle.
- Storage: two banks of BANK_DEPTH x PAYLOAD_DATA_WIDTH. Each bank has a full flag, a length register (clog2(BANK_DEPTH)+1 bits) and a listnum register.
- Write FSM states: W_IDLE, W_FILL, W_WAIT_VERDICT, W_SKIP.
  - W_IDLE: on start&valid:
    - If bank[wr_bank] is not full: write the byte at address 0, set len=1, clear verdict_seen, go to W_FILL.
    - Otherwise: pulse in_overflow, increment pkt_drop_cnt, go to W_SKIP.
  - W_FILL: each valid byte is written at address len, then len++.
    - If len reaches BANK_DEPTH and another byte arrives, mark the packet truncated.
    - start&valid while in W_FILL: abort the current packet (drop, pkt_drop_cnt++) and restart at address 0 in the same bank with this byte.
    - end&valid: if verdict_seen, commit that cycle; otherwise go to W_WAIT_VERDICT with the timeout counter cleared.
  - Verdict capture: search_over while in W_FILL latches t_match/t_match_listnum and sets verdict_seen. search_over in W_IDLE or W_SKIP is ignored.
  - W_WAIT_VERDICT: on search_over, commit. If the counter reaches VERDICT_TIMEOUT, drop and go to W_IDLE.
    - start&valid in this state: treat as a timeout drop, then process the start as in W_IDLE in the same cycle.
  - Commit:
    - If matched and not truncated: set full, store len and listnum, pkt_pass_cnt++, toggle wr_bank.
    - Otherwise: pulse in_overflow only when truncated, pkt_drop_cnt++, leave the bank empty.
    - Return to W_IDLE.
  - W_SKIP: ignore bytes until end&valid (go to W_IDLE) or start&valid (re-evaluate as in W_IDLE).
- Read FSM states: R_IDLE, R_PREFETCH, R_OUT.
  - When bank[rd_bank] is full, go to R_PREFETCH (one-cycle RAM read latency), then R_OUT.
  - payload_out_valid first rises 2 cycles after the commit edge.
  - Valid/ready handshake: a byte transfers when valid&ready. While ready=0, data, start, end and listnum are held stable.
  - payload_out_start is high on byte 0; payload_out_end is high on byte len-1. A 1-byte packet has start and end on the same byte.
  - Gapless output when ready stays high.
  - When the end byte transfers: clear full, toggle rd_bank, return to R_IDLE; a pending full bank can start next cycle.
- Ordering: banks fill and drain alternately, so output order equals input order.
- Commit to one bank and release of the other in the same cycle are both honoured.
- Counters increment at most once per cycle; simultaneous pass and drop events update their separate counters independently.

Test Plan:
- 16-byte packet, search_over with t_match=1 and listnum=5 on byte 10, ready=1 → 16 bytes out unchanged, start on byte 0, end on byte 15, listnum=5, pkt_pass_cnt=1.
- Same packet with t_match=0 → no output, pkt_drop_cnt=1, in_overflow stays 0.
- Verdict never arrives → drop exactly VERDICT_TIMEOUT (64) cycles after end; pkt_drop_cnt=1. search_over arriving 3 cycles after end with a match → passed.
- Three back-to-back matched 188-byte packets with ready=0 → first two fill both banks, third pulses in_overflow and is dropped. Releasing ready yields packets 1 then 2 intact.
- 300-byte packet with BANK_DEPTH=256, matched → dropped, in_overflow pulse, no output. Random ready toggling on a 20-byte packet → bytes unchanged, no duplicates, no gaps.
- Assert payload_rst_n mid-replay → outputs 0 immediately, both banks empty. The next packet after reset passes normally.
